// File: rtl/reg_wb_ctrl.sv
// Writeback controller: arbitrates ALU results against a small FIFO of
// memory results for the single register-file write port, tracks pending
// destination registers, and keeps the FIFO from starving under ALU load.
module reg_wb_ctrl #(
    parameter int DEPTH      = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic        clk_w_i,
    input  logic        res_w_i_l,
    input  logic        alu_vld_w_i,
    output logic        alu_rdy_w_o,
    input  logic [4:0]  alu_rd_w_i,
    input  logic [31:0] alu_data_w_i,
    input  logic        mem_vld_w_i,
    output logic        mem_rdy_w_o,
    input  logic [4:0]  mem_rd_w_i,
    input  logic [31:0] mem_data_w_i,
    input  logic        issue_vld_w_i,
    input  logic [4:0]  issue_rd_w_i,
    output logic [31:0] pend_w_o,
    output logic        reg_wr_flag_w_o,
    output logic [4:0]  wr_reg_w_o,
    output logic [31:0] wr_data_w_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int STV_W = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;

    // FIFO storage; DEPTH is a power of two so pointers wrap naturally
    logic [4:0]  fifo_rd_q   [DEPTH];
    logic [31:0] fifo_data_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic [31:0]      pend_q, pend_d;
    logic             flag_q, flag_d;
    logic [4:0]       wr_reg_q, wr_reg_d;
    logic [31:0]      wr_data_q, wr_data_d;

    logic        fifo_full, fifo_empty, force_fifo;
    logic        alu_grant, pop, push, win_vld;
    logic [4:0]  win_rd;
    logic [31:0] win_data;
    logic [31:0] set_vec, clr_vec;

    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign fifo_empty = (count_q == '0);
    // Once the ALU has held the port STARVE_LIM times against a full FIFO,
    // the FIFO head takes the next slot.
    assign force_fifo = fifo_full && (starve_q == STV_W'(STARVE_LIM));

    assign alu_rdy_w_o = !force_fifo;
    assign mem_rdy_w_o = !fifo_full;

    assign alu_grant = alu_vld_w_i && !force_fifo;
    assign pop       = !alu_grant && !fifo_empty;
    assign push      = mem_vld_w_i && mem_rdy_w_o;
    assign win_vld   = alu_grant || pop;
    assign win_rd    = alu_grant ? alu_rd_w_i   : fifo_rd_q[rd_ptr_q];
    assign win_data  = alu_grant ? alu_data_w_i : fifo_data_q[rd_ptr_q];

    assign set_vec = (issue_vld_w_i && (issue_rd_w_i != 5'd0)) ? (32'd1 << issue_rd_w_i) : 32'd0;
    assign clr_vec = win_vld ? (32'd1 << win_rd) : 32'd0;

    assign pend_w_o        = pend_q;
    assign reg_wr_flag_w_o = flag_q;
    assign wr_reg_w_o      = wr_reg_q;
    assign wr_data_w_o     = wr_data_q;

    // Next-state logic for FIFO bookkeeping, starvation, scoreboard and write port
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        starve_d  = starve_q;
        flag_d    = 1'b0;
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (pop || !fifo_full)
            starve_d = '0;
        else if (alu_grant && (starve_q != STV_W'(STARVE_LIM)))
            starve_d = starve_q + 1'b1;

        // A later issue to the same register must survive this cycle's clear
        pend_d    = (pend_q & ~clr_vec) | set_vec;
        pend_d[0] = 1'b0;

        // x0 winners are consumed silently; the write port holds its last value
        if (win_vld && (win_rd != 5'd0)) begin
            flag_d    = 1'b1;
            wr_reg_d  = win_rd;
            wr_data_d = win_data;
        end
    end

    // Control and output registers with asynchronous clear
    always_ff @(posedge clk_w_i or negedge res_w_i_l) begin
        if (!res_w_i_l) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            pend_q    <= '0;
            flag_q    <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            pend_q    <= pend_d;
            flag_q    <= flag_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
        end
    end

    // FIFO payload write; contents are don't-care until counted as occupied
    always_ff @(posedge clk_w_i) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= mem_rd_w_i;
            fifo_data_q[wr_ptr_q] <= mem_data_w_i;
        end
    end

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Directed bench for reg_wb_ctrl: a queue-based model of the writeback rules
// is checked every cycle, plus literal expectations for the key scenarios.
module tb_reg_wb_ctrl;

    localparam int DEPTH = 2;
    localparam int LIM   = 4;

    logic        clk, rst_n;
    logic        alu_vld, alu_rdy, mem_vld, mem_rdy, issue_vld, flag;
    logic [4:0]  alu_rd, mem_rd, issue_rd, wr_reg;
    logic [31:0] alu_data, mem_data, pend, wr_data;

    int checks = 0;
    int errors = 0;

    reg_wb_ctrl #(.DEPTH(DEPTH), .STARVE_LIM(LIM)) dut (
        .clk_w_i        (clk),
        .res_w_i_l      (rst_n),
        .alu_vld_w_i    (alu_vld),
        .alu_rdy_w_o    (alu_rdy),
        .alu_rd_w_i     (alu_rd),
        .alu_data_w_i   (alu_data),
        .mem_vld_w_i    (mem_vld),
        .mem_rdy_w_o    (mem_rdy),
        .mem_rd_w_i     (mem_rd),
        .mem_data_w_i   (mem_data),
        .issue_vld_w_i  (issue_vld),
        .issue_rd_w_i   (issue_rd),
        .pend_w_o       (pend),
        .reg_wr_flag_w_o(flag),
        .wr_reg_w_o     (wr_reg),
        .wr_data_w_o    (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [36:0] m_q[$];          // {rd, data} in arrival order
    int          m_starve = 0;
    logic [31:0] m_pend   = '0;
    logic        m_flag   = 1'b0;
    logic [4:0]  m_reg    = '0;
    logic [31:0] m_data   = '0;

    always @(posedge clk) begin
        int          sz;
        bit          full, forced, alu_win, popped, won, do_push;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        logic [36:0] ent;
        if (rst_n) begin
            sz      = m_q.size();
            full    = (sz == DEPTH);
            forced  = full && (m_starve == LIM);
            do_push = mem_vld && (sz < DEPTH);
            alu_win = alu_vld && !forced;
            popped  = 0;
            won     = 0;
            wrd     = '0;
            wdat    = '0;
            if (alu_win) begin
                won = 1; wrd = alu_rd; wdat = alu_data;
            end else if (sz > 0) begin
                ent = m_q.pop_front();
                won = 1; popped = 1; wrd = ent[36:32]; wdat = ent[31:0];
            end
            if (do_push) m_q.push_back({mem_rd, mem_data});
            if (popped || !full) m_starve = 0;
            else if (alu_win && m_starve < LIM) m_starve++;
            if (won) m_pend[wrd] = 1'b0;
            if (issue_vld) m_pend[issue_rd] = 1'b1;
            m_pend[0] = 1'b0;
            if (won && wrd != 5'd0) begin
                m_flag = 1'b1; m_reg = wrd; m_data = wdat;
            end else begin
                m_flag = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_flag", {31'd0, flag}, 32'd0);
            chk("rst_wr_reg", {27'd0, wr_reg}, 32'd0);
            chk("rst_wr_data", wr_data, 32'd0);
            chk("rst_pend", pend, 32'd0);
            chk("rst_mem_rdy", {31'd0, mem_rdy}, 32'd1);
            chk("rst_alu_rdy", {31'd0, alu_rdy}, 32'd1);
            m_q.delete();
            m_starve = 0; m_pend = '0; m_flag = 1'b0; m_reg = '0; m_data = '0;
        end else begin
            chk("flag", {31'd0, flag}, {31'd0, m_flag});
            chk("wr_reg", {27'd0, wr_reg}, {27'd0, m_reg});
            chk("wr_data", wr_data, m_data);
            chk("pend", pend, m_pend);
            chk("alu_rdy", {31'd0, alu_rdy}, {31'd0, !((m_q.size() == DEPTH) && (m_starve == LIM))});
            chk("mem_rdy", {31'd0, mem_rdy}, {31'd0, (m_q.size() < DEPTH)});
            if (flag) $display("write x%0d <= %h at %0t", wr_reg, wr_data, $time);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_vld = 0; mem_vld = 0; issue_vld = 0;
    endtask

    initial begin
        rst_n = 0; idle();
        alu_rd = 0; alu_data = 0; mem_rd = 0; mem_data = 0; issue_rd = 0;
        repeat (3) step();
        rst_n = 1;
        #1;
        chk("lit_reset_flag", {31'd0, flag}, 32'd0);
        chk("lit_reset_pend", pend, 32'd0);
        chk("lit_reset_mem_rdy", {31'd0, mem_rdy}, 32'd1);
        chk("lit_reset_alu_rdy", {31'd0, alu_rdy}, 32'd1);

        // ALU only
        alu_vld = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        step();
        chk("lit_alu_flag", {31'd0, flag}, 32'd1);
        chk("lit_alu_reg", {27'd0, wr_reg}, 32'd5);
        chk("lit_alu_data", wr_data, 32'hDEADBEEF);
        idle();
        step();
        chk("lit_alu_flag_drop", {31'd0, flag}, 32'd0);
        chk("lit_alu_hold_reg", {27'd0, wr_reg}, 32'd5);

        // x0 is never written nor marked pending
        issue_vld = 1; issue_rd = 0;
        step();
        idle(); alu_vld = 1; alu_rd = 0; alu_data = 32'h12345678;
        step();
        chk("lit_x0_flag", {31'd0, flag}, 32'd0);
        chk("lit_x0_pend", pend, 32'd0);
        idle();
        step();

        // Simultaneous ALU and memory results
        issue_vld = 1; issue_rd = 3; step();
        issue_rd = 4; step();
        idle();
        alu_vld = 1; alu_rd = 3; alu_data = 32'hA1A1A1A1;
        mem_vld = 1; mem_rd = 4; mem_data = 32'hB2B2B2B2;
        step();
        chk("lit_sim_alu_reg", {27'd0, wr_reg}, 32'd3);
        chk("lit_sim_pend1", pend, 32'h00000010);
        idle();
        step();
        chk("lit_sim_mem_flag", {31'd0, flag}, 32'd1);
        chk("lit_sim_mem_reg", {27'd0, wr_reg}, 32'd4);
        chk("lit_sim_mem_data", wr_data, 32'hB2B2B2B2);
        chk("lit_sim_pend2", pend, 32'd0);
        step();

        // Starvation: fill the FIFO while the ALU keeps the port busy
        alu_vld = 1; alu_rd = 1; alu_data = 32'h00000111;
        mem_vld = 1; mem_rd = 9; mem_data = 32'h0000AAAA;
        step();
        mem_rd = 10; mem_data = 32'h0000BBBB;
        step();
        mem_vld = 0;
        #1;
        chk("lit_stv_full_alu_rdy", {31'd0, alu_rdy}, 32'd1);
        chk("lit_stv_full_mem_rdy", {31'd0, mem_rdy}, 32'd0);
        repeat (4) step();
        chk("lit_stv_forced", {31'd0, alu_rdy}, 32'd0);
        chk("lit_stv_last_alu_reg", {27'd0, wr_reg}, 32'd1);
        step();
        chk("lit_stv_head_reg", {27'd0, wr_reg}, 32'd9);
        chk("lit_stv_head_data", wr_data, 32'h0000AAAA);
        chk("lit_stv_release", {31'd0, alu_rdy}, 32'd1);
        idle();
        step();
        chk("lit_stv_second_reg", {27'd0, wr_reg}, 32'd10);
        step();

        // Scoreboard race on x7
        issue_vld = 1; issue_rd = 7; step();
        alu_vld = 1; alu_rd = 7; alu_data = 32'h77777777;
        step();
        chk("lit_race_pend7", {31'd0, pend[7]}, 32'd1);
        chk("lit_race_reg", {27'd0, wr_reg}, 32'd7);
        issue_vld = 0;
        step();
        chk("lit_race_clear", {31'd0, pend[7]}, 32'd0);
        idle();
        step();

        // FIFO ordering across pointer wrap with intermittent ALU traffic
        for (int i = 0; i < 6; i++) begin
            mem_vld = 1; mem_rd = 5'(11 + i); mem_data = 32'h01010101 * i + 32'h100;
            alu_vld = (i % 2 == 1); alu_rd = 5'(20 + i); alu_data = 32'hC0DE0000 + i;
            step();
        end
        idle();
        repeat (6) step();

        // Reset mid-flight
        issue_vld = 1; issue_rd = 4; step();
        issue_rd = 7; step();
        issue_vld = 0;
        alu_vld = 1; alu_rd = 1; alu_data = 32'h1;
        mem_vld = 1; mem_rd = 4; mem_data = 32'h44444444; step();
        mem_rd = 7; mem_data = 32'h77770000; step();
        idle();
        chk("lit_mid_pend", pend, 32'h00000090);
        chk("lit_mid_full", {31'd0, mem_rdy}, 32'd0);
        rst_n = 0;
        #1;
        chk("lit_mid_rst_flag", {31'd0, flag}, 32'd0);
        chk("lit_mid_rst_pend", pend, 32'd0);
        chk("lit_mid_rst_data", wr_data, 32'd0);
        chk("lit_mid_rst_mem_rdy", {31'd0, mem_rdy}, 32'd1);
        repeat (2) step();
        rst_n = 1;
        repeat (3) begin
            step();
            chk("lit_post_rst_flag", {31'd0, flag}, 32'd0);
        end
        chk("lit_post_rst_pend", pend, 32'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_wb_ctrl.md
REG_WB_CTRL -- requirements
Module: reg_wb_ctrl

Interface
REQ-001 Parameter DEPTH, default 2: memory-result FIFO depth in entries; power of two, 2..8.
REQ-002 Parameter STARVE_LIM, default 4: consecutive ALU grants allowed while the FIFO is full.
REQ-003 clk_w_i  input  1  sole clock; all state changes on its rising edge.
REQ-004 res_w_i_l  input  1  asynchronous, active-low reset.
REQ-005 alu_vld_w_i  input  1  ALU result valid.
REQ-006 alu_rdy_w_o  output  1  ALU result accepted this cycle; combinational.
REQ-007 alu_rd_w_i  input  5  ALU destination register index.
REQ-008 alu_data_w_i  input  32  ALU result data.
REQ-009 mem_vld_w_i  input  1  memory/multicycle result valid.
REQ-010 mem_rdy_w_o  output  1  FIFO can accept a memory result.
REQ-011 mem_rd_w_i  input  5  memory destination register index.
REQ-012 mem_data_w_i  input  32  memory result data.
REQ-013 issue_vld_w_i  input  1  instruction issued; marks its destination pending.
REQ-014 issue_rd_w_i  input  5  destination index of the issued instruction.
REQ-015 pend_w_o  output  32  pending-write bitmap; bit n set means xn awaits writeback.
REQ-016 reg_wr_flag_w_o  output  1  register-file write enable; registered.
REQ-017 wr_reg_w_o  output  5  register-file write index; registered.
REQ-018 wr_data_w_o  output  32  register-file write data; registered.

Function
REQ-019 The block shall be the sole driver of the register file's single write port; the register file captures the write on the clock edge after reg_wr_flag_w_o rises.
REQ-020 A memory result shall be pushed into the FIFO when mem_vld_w_i and mem_rdy_w_o are both high.
REQ-021 mem_rdy_w_o shall be high exactly when the FIFO occupancy is below DEPTH; a push and a pop in the same cycle shall leave the occupancy unchanged.
REQ-022 Arbitration each cycle:
- When the FIFO is full and the starvation counter equals STARVE_LIM, the FIFO head wins and alu_rdy_w_o is low.
- Otherwise, when alu_vld_w_i is high, the ALU wins and alu_rdy_w_o is high.
- Otherwise, when the FIFO is non-empty, the FIFO head wins and is popped.
REQ-023 When no ALU result is valid, alu_rdy_w_o shall be high unless the FIFO is forced per REQ-022.
REQ-024 The starvation counter shall increment on each ALU grant while the FIFO is full, saturate at STARVE_LIM, and clear on any FIFO pop or whenever the FIFO is not full.
REQ-025 The winner's index and data shall appear on wr_reg_w_o and wr_data_w_o one cycle after the grant, with reg_wr_flag_w_o high for exactly that cycle.
REQ-026 A winner with index 0 shall be consumed, or popped if it came from the FIFO, with reg_wr_flag_w_o held low; x0 is never written.
REQ-027 When reg_wr_flag_w_o is low, wr_reg_w_o and wr_data_w_o shall hold their previous values.
REQ-028 Scoreboard updates:
- issue_vld_w_i with a nonzero index sets that pend_w_o bit on the next edge.
- A grant clears its index's bit on the next edge.
- A simultaneous set and clear of the same index leaves the bit set.
- Bit 0 is always 0.
REQ-029 FIFO ordering shall be strict first-in first-out, and read/write pointers shall wrap modulo DEPTH.
REQ-030 A memory push into an empty FIFO shall not bypass it; the earliest write for that result occurs two edges after the push.

Reset
REQ-031 While res_w_i_l is low, the block shall asynchronously clear:
- FIFO pointers and occupancy, and the starvation counter;
- pend_w_o to 0;
- reg_wr_flag_w_o, wr_reg_w_o and wr_data_w_o to 0.
REQ-032 During reset, mem_rdy_w_o shall be high and alu_rdy_w_o shall be high.
REQ-033 Reset asserted mid-operation shall discard buffered results with no partial write; reset deassertion shall take effect on the next rising edge.

Verification
REQ-034 ALU only: alu_vld=1, rd=5, data=0xDEADBEEF -> next cycle flag=1, wr_reg=5, wr_data=0xDEADBEEF; following cycle flag=0.
REQ-035 x0 drop: issue rd=0, then an ALU result rd=0 -> flag stays 0 and pend_w_o stays 0x00000000.
REQ-036 Simultaneous sources: ALU rd=3 and memory rd=4 in the same cycle:
- The ALU write appears at edge+1.
- The memory write appears at edge+2 when the ALU is idle.
- pend bits 3 and 4 clear in order.
REQ-037 Starvation: fill the FIFO (DEPTH=2) and hold alu_vld high -> 4 ALU grants, then alu_rdy=0 for one cycle, the FIFO head is written, and the counter resets.
REQ-038 Scoreboard race: issue rd=7 in the same cycle that rd=7 is granted -> pend_w_o[7] remains 1.
REQ-039 Reset mid-flight: FIFO holding 2 entries and pend=0x00000090, drive res_w_i_l low -> outputs 0, pend 0, mem_rdy=1, and no write after release.
